// File: rtl/count_sequencer_if.sv
// Control/status bundle between a run controller and the count sequencer.
// The controller side drives the run requests; the sequencer side returns the count and run flags.
interface count_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             hold;
    logic             dir_up;
    logic             periodic;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, hold, dir_up, periodic, limit,
        input  out, busy, tc, done
    );

    modport slave (
        input  start, stop, hold, dir_up, periodic, limit,
        output out, busy, tc, done
    );
endinterface

// File: rtl/count_sequencer.sv
// Sequenced up/down counter with prescaled stepping, terminal-count flag,
// one-shot or periodic runs, hold/resume and abort. All outputs are registered.
module count_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rstn,
    count_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0]       PRESC_LAST = 8'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r, state_s;
    logic [WIDTH-1:0] out_r, out_s;
    logic [WIDTH-1:0] lim_r, lim_s;
    logic             dir_r, dir_s;
    logic             per_r, per_s;
    logic [7:0]       presc_r, presc_s;
    logic             busy_r, busy_s;
    logic             tc_r, tc_s;
    logic             done_r, done_s;

    logic [WIDTH-1:0] end_val_s;
    logic [WIDTH-1:0] start_val_s;
    logic [WIDTH-1:0] stepped_s;

    // Value the counter moves to on a step; sitting on the end value means a periodic reload
    always_comb begin
        end_val_s   = dir_r ? lim_r : ZERO;
        start_val_s = dir_r ? ZERO  : lim_r;
        if (out_r == end_val_s) begin
            stepped_s = start_val_s;
        end else if (dir_r) begin
            stepped_s = out_r + ONE;
        end else begin
            stepped_s = out_r - ONE;
        end
    end

    // Next-state and next-output logic; stop outranks every other request
    always_comb begin
        state_s = state_r;
        out_s   = out_r;
        lim_s   = lim_r;
        dir_s   = dir_r;
        per_s   = per_r;
        presc_s = presc_r;
        tc_s    = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.stop) begin
                    out_s = ZERO;
                end else if (bus.start) begin
                    state_s = RUN;
                    out_s   = bus.dir_up ? ZERO : bus.limit;
                    presc_s = 8'd0;
                    lim_s   = bus.limit;
                    dir_s   = bus.dir_up;
                    per_s   = bus.periodic;
                end else begin
                    out_s = out_r;
                end
            end
            RUN, HOLD: begin
                if (bus.stop) begin
                    state_s = IDLE;
                    out_s   = ZERO;
                    done_s  = 1'b1;
                end else if (bus.hold) begin
                    state_s = HOLD;
                end else if (presc_r == PRESC_LAST) begin
                    // Leaving HOLD steps on the same edge so a hold of n edges delays by n
                    state_s = RUN;
                    presc_s = 8'd0;
                    out_s   = stepped_s;
                    if (stepped_s == end_val_s) begin
                        tc_s = 1'b1;
                        if (!per_r) begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = RUN;
                        end
                    end else begin
                        tc_s = 1'b0;
                    end
                end else begin
                    state_s = RUN;
                    presc_s = presc_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                out_s   = ZERO;
                presc_s = 8'd0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_r <= IDLE;
            out_r   <= ZERO;
            lim_r   <= ZERO;
            dir_r   <= 1'b0;
            per_r   <= 1'b0;
            presc_r <= 8'd0;
            busy_r  <= 1'b0;
            tc_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            out_r   <= out_s;
            lim_r   <= lim_s;
            dir_r   <= dir_s;
            per_r   <= per_s;
            presc_r <= presc_s;
            busy_r  <= busy_s;
            tc_r    <= tc_s;
            done_r  <= done_s;
        end
    end

    assign bus.out  = out_r;
    assign bus.busy = busy_r;
    assign bus.tc   = tc_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench: a phase-count reference model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the sequencer.
module tb_count_sequencer;

    localparam int W = 4;
    localparam int P = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    count_sequencer_if #(.WIDTH(W)) bus ();

    count_sequencer #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct {
        int out;
        bit busy;
        bit tc;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: a run is a count of active cycles since start
    bit m_run;
    int m_phase;
    int m_lim;
    int m_out;
    bit m_dir;
    bit m_per;
    bit m_tc;
    bit m_done;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_phase = 0; m_lim = 0; m_out = 0;
        m_dir = 1'b0; m_per = 1'b0; m_tc = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        int steps;
        int pos;
        m_tc   = 1'b0;
        m_done = 1'b0;
        if (!m_run) begin
            if (bus.stop) begin
                m_out = 0;
            end else if (bus.start) begin
                m_run   = 1'b1;
                m_phase = 0;
                m_lim   = int'(bus.limit);
                m_dir   = bus.dir_up;
                m_per   = bus.periodic;
                m_out   = m_dir ? 0 : m_lim;
            end
        end else if (bus.stop) begin
            m_run  = 1'b0;
            m_out  = 0;
            m_done = 1'b1;
        end else if (!bus.hold) begin
            m_phase++;
            if (m_phase % P == 0) begin
                steps = m_phase / P;
                pos   = steps % (m_lim + 1);
                m_out = m_dir ? pos : (m_lim - pos);
                if (pos == m_lim) begin
                    m_tc = 1'b1;
                    if (!m_per) begin
                        m_done = 1'b1;
                        m_run  = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_edge();
        e.out  = m_out;
        e.busy = m_run;
        e.tc   = m_tc;
        e.done = m_done;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic start_run(input bit d, input bit per, input int lim);
        bus.dir_up   = d;
        bus.periodic = per;
        bus.limit    = W'(lim);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        // Scramble the live config to show it was latched
        bus.dir_up   = ~d;
        bus.periodic = ~per;
        bus.limit    = W'($urandom_range(0, 15));
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (m_run && n < budget) begin
            tick();
            n++;
        end
        check("run_timeout", int'(m_run), 0);
    endtask

    task automatic run_until_out(input int value, input int budget);
        int n = 0;
        while (m_out != value && n < budget) begin
            tick();
            n++;
        end
        check("reach_timeout", m_out, value);
    endtask

    // Monitor: one expected record per clock edge, compared away from the edge
    always @(negedge clk) begin
        if (!rstn && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("out",  int'(bus.out),  mon_e.out);
            check("busy", int'(bus.busy), int'(mon_e.busy));
            check("tc",   int'(bus.tc),   int'(mon_e.tc));
            check("done", int'(bus.done), int'(mon_e.done));
        end
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
        bus.dir_up = 1'b0; bus.periodic = 1'b0; bus.limit = '0;
        model_reset();
        #12;
        check("rst_out",  int'(bus.out),  0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_tc",   int'(bus.tc),   0);
        check("rst_done", int'(bus.done), 0);
        @(negedge clk);
        rstn = 1'b0;
        tick();

        // Up one-shot lim=5
        start_run(1'b1, 1'b0, 5);
        run_until_idle(100);
        repeat (3) tick();

        // Down periodic lim=3, then abort
        start_run(1'b0, 1'b1, 3);
        repeat (20) tick();
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        repeat (2) tick();

        // Hold at 7 for 4 cycles, stop together with start at 10
        start_run(1'b1, 1'b0, 15);
        run_until_out(7, 100);
        bus.hold = 1'b1; repeat (4) tick(); bus.hold = 1'b0;
        run_until_out(10, 100);
        bus.stop = 1'b1; bus.start = 1'b1; tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        repeat (3) tick();

        // Degenerate lim=0 one-shot
        start_run(1'b1, 1'b0, 0);
        run_until_idle(20);
        tick();

        // Start pulses during a lim=8 run are ignored
        start_run(1'b1, 1'b0, 8);
        repeat (5) begin
            bus.start = 1'b1; tick(); bus.start = 1'b0; tick();
        end
        run_until_idle(100);
        tick();

        // Asynchronous reset mid-run, then a fresh run
        start_run(1'b1, 1'b0, 9);
        run_until_out(5, 100);
        #2;
        rstn = 1'b1;
        #1;
        check("mid_rst_out",  int'(bus.out),  0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_tc",   int'(bus.tc),   0);
        check("mid_rst_done", int'(bus.done), 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rstn = 1'b0;
        start_run(1'b1, 1'b0, 9);
        run_until_idle(100);
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.start    = ($urandom_range(0, 7) == 0);
            bus.stop     = ($urandom_range(0, 39) == 0);
            bus.hold     = ($urandom_range(0, 5) == 0);
            bus.dir_up   = 1'($urandom_range(0, 1));
            bus.periodic = 1'($urandom_range(0, 1));
            bus.limit    = W'($urandom_range(0, 15));
            tick();
        end
        bus.start = 1'b0; bus.hold = 1'b0; bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        repeat (3) tick();
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
